// File: rtl/ssd_scan_driver_if.sv
// ssd_scan_driver_if
//   Bundles the display-facing signals of the seven-segment scan driver.
//   Signals:
//     ssd        [19:0] four 5-bit symbol codes, [19:15] = digit 3 (leftmost)
//     blink_mask [3:0]  per-digit blink enable, bit i = digit i
//     alert             whole-display blink request
//     AN         [3:0]  active-low anodes, AN[i] = digit i
//     seven_out  [6:0]  active-low segments {a,b,c,d,e,f,g}
//   Modports:
//     master - the producer of symbol codes (drives codes, reads display)
//     slave  - the scan driver itself
interface ssd_scan_driver_if;
   logic [19:0] ssd;
   logic [3:0]  blink_mask;
   logic        alert;
   logic [3:0]  AN;
   logic [6:0]  seven_out;

   modport master (
      output ssd,
      output blink_mask,
      output alert,
      input  AN,
      input  seven_out
   );

   modport slave (
      input  ssd,
      input  blink_mask,
      input  alert,
      output AN,
      output seven_out
   );
endinterface

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
//   Time-multiplexed driver for a four-digit common-anode seven-segment
//   display. Each digit slot lasts REFRESH_DIV clocks; the first DEAD_CYC
//   clocks of a slot keep all anodes off to avoid ghosting. Digits are
//   scanned 3,2,1,0. Symbol codes are captured into a frame buffer only at
//   the end of a full scan so a frame never mixes old and new codes.
//   Optional blinking is built only when the macro SSD_BLINK_EN is defined.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  ssd_scan_driver_if.slave (ssd, blink_mask, alert in; AN, seven_out out)
//   Parameters:
//     REFRESH_DIV clocks per digit slot
//     DEAD_CYC    anode-off clocks at slot start (must be < REFRESH_DIV)
//     BLINK_DIV   clocks per blink half-period
module ssd_scan_driver #(
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYC    = 500,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic             clk,
   input  logic             rst,
   ssd_scan_driver_if.slave bus
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [4:0] BLANK_CODE = 5'd19;

   // Symbol code to active-low segment pattern {a,b,c,d,e,f,g}.
   function automatic logic [6:0] seg_decode(input logic [4:0] code);
      logic [6:0] seg;
      case (code)
         5'd0:    seg = 7'b0000001;
         5'd1:    seg = 7'b1001111;
         5'd2:    seg = 7'b0010010;
         5'd3:    seg = 7'b0000110;
         5'd4:    seg = 7'b1001100;
         5'd5:    seg = 7'b0100100;
         5'd6:    seg = 7'b0100000;
         5'd7:    seg = 7'b0001111;
         5'd8:    seg = 7'b0000000;
         5'd9:    seg = 7'b0000100;
         5'd10:   seg = 7'b0110001; // C
         5'd11:   seg = 7'b1110001; // L
         5'd12:   seg = 7'b0100100; // S
         5'd13:   seg = 7'b1000010; // d
         5'd14:   seg = 7'b0000001; // O
         5'd15:   seg = 7'b0011000; // P
         5'd16:   seg = 7'b0110000; // E
         5'd17:   seg = 7'b1101010; // n
         5'd18:   seg = 7'b1111110; // dash
         5'd20:   seg = 7'b1101000; // h
         default: seg = 7'b1111111; // 19 and 21-31 are blank
      endcase
      return seg;
   endfunction

   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       idx_r;
   logic [19:0]      fb_ssd_r;
   logic [3:0]       an_r;
   logic [6:0]       seg_r;
   logic             wrap_s;
   logic             latch_s;
   logic [4:0]       code_s;
   logic             blank_s;
   logic [3:0]       an_next_s;
   logic [6:0]       seg_next_s;

   assign wrap_s  = (cnt_r == CNT_W'(REFRESH_DIV - 1));
   assign latch_s = wrap_s && (idx_r == 2'd0);

   // Slot counter, digit index and end-of-scan frame buffer capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r    <= '0;
         idx_r    <= 2'd3;
         fb_ssd_r <= {4{BLANK_CODE}};
      end else begin
         if (wrap_s) begin
            cnt_r <= '0;
            idx_r <= idx_r - 2'd1;   // 0 wraps naturally to 3
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if (latch_s) begin
            fb_ssd_r <= bus.ssd;
         end
      end
   end

`ifdef SSD_BLINK_EN
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BLK_W-1:0] bcnt_r;
   logic             phase_r;
   logic [3:0]       fb_mask_r;
   logic             fb_alert_r;

   // Free-running blink timer; phase 1 = digits on, 0 = blinkable digits off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt_r  <= '0;
         phase_r <= 1'b1;
      end else if (bcnt_r == BLK_W'(BLINK_DIV - 1)) begin
         bcnt_r  <= '0;
         phase_r <= ~phase_r;
      end else begin
         bcnt_r  <= bcnt_r + BLK_W'(1);
      end
   end

   // Blink controls are buffered together with the codes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fb_mask_r  <= 4'b0000;
         fb_alert_r <= 1'b0;
      end else if (latch_s) begin
         fb_mask_r  <= bus.blink_mask;
         fb_alert_r <= bus.alert;
      end else begin
         fb_mask_r  <= fb_mask_r;
         fb_alert_r <= fb_alert_r;
      end
   end

   // Blank the active digit during the off phase if it or the whole display blinks.
   always_comb begin
      blank_s = 1'b0;
      if (!phase_r) begin
         blank_s = fb_mask_r[idx_r] | fb_alert_r;
      end else begin
         blank_s = 1'b0;
      end
   end
`else
   logic unused_blink_s;
   assign unused_blink_s = ^{bus.blink_mask, bus.alert};

   // Without blinking no digit is ever blanked.
   always_comb begin
      blank_s = 1'b0;
   end
`endif

   // Next anode/segment values from the current slot state and frame buffer.
   always_comb begin
      code_s     = BLANK_CODE;
      an_next_s  = 4'b1111;
      seg_next_s = 7'b1111111;
      case (idx_r)
         2'd3:    code_s = fb_ssd_r[19:15];
         2'd2:    code_s = fb_ssd_r[14:10];
         2'd1:    code_s = fb_ssd_r[9:5];
         2'd0:    code_s = fb_ssd_r[4:0];
         default: code_s = BLANK_CODE;
      endcase
      if (cnt_r < CNT_W'(DEAD_CYC)) begin
         an_next_s = 4'b1111;
      end else begin
         an_next_s = ~(4'b0001 << idx_r);
      end
      if (blank_s) begin
         seg_next_s = 7'b1111111;
      end else begin
         seg_next_s = seg_decode(code_s);
      end
   end

   // Output registers; reset forces the display dark immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_r  <= 4'b1111;
         seg_r <= 7'b1111111;
      end else begin
         an_r  <= an_next_s;
         seg_r <= seg_next_s;
      end
   end

   assign bus.AN        = an_r;
   assign bus.seven_out = seg_r;

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clk cycles per digit slot.
REQ-002 Parameter DEAD_CYC, default 500: anode-off cycles at the start of each slot (ghosting guard); SHALL satisfy DEAD_CYC < REFRESH_DIV.
REQ-003 Parameter BLINK_DIV, default 25000000: clk cycles per blink half-period.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 ssd  input  20  four 5-bit symbol codes; [19:15] is the leftmost digit (digit 3), [4:0] is the rightmost digit (digit 0).
REQ-007 blink_mask  input  4  per-digit blink enable; bit i maps to digit i.
REQ-008 alert  input  1  whole-display blink request (backdoor indication).
REQ-009 AN  output  4  active-low anodes; AN[i] drives digit i.
REQ-010 seven_out  output  7  active-low segments {a,b,c,d,e,f,g}; bit 6 is segment a.

Function
REQ-011 Symbol decode SHALL map 0-9 to digits 0-9, 10 to C, 11 to L, 12 to S, 13 to d, 14 to O, 15 to P, 16 to E, 17 to n, 18 to dash (g only), 19 to blank, 20 to h, and 21-31 to blank.
REQ-012 Slot counter cnt SHALL count 0..REFRESH_DIV-1 and then wrap to 0; on each wrap, digit index idx SHALL step 3->2->1->0->3.
REQ-013 On the edge where cnt==REFRESH_DIV-1 and idx==0, the block SHALL latch ssd, blink_mask and alert into a frame buffer; input changes at any other time SHALL NOT affect the display until the next latch (no tearing).
REQ-014 While cnt<DEAD_CYC, AN SHALL be 4'b1111; otherwise AN SHALL be one-hot low at bit idx.
REQ-015 seven_out SHALL be the decode of the buffered code for digit idx, or 7'b1111111 when that digit is blanked per REQ-017.
REQ-016 AN and seven_out SHALL be registered: the value in cycle k SHALL reflect cnt, idx, phase and the frame buffer as they stood in cycle k-1.
REQ-017 Blink counter SHALL count 0..BLINK_DIV-1 and, on wrap, toggle phase (1=on, 0=off). During phase 0, digit i SHALL be blanked if buffered blink_mask[i]=1 or buffered alert=1; AN timing SHALL be unaffected.
REQ-018 The blink counter SHALL free-run, independent of the slot counter and of the latch events.

Reset
REQ-019 On rst assertion, regardless of clk: AN=4'b1111, seven_out=7'b1111111, cnt=0, idx=3, blink counter=0, phase=1, frame buffer = four blank codes (19), buffered mask=0, buffered alert=0.
REQ-020 Reset asserted mid-slot or mid-blink SHALL abort immediately; the first full scan after release SHALL display blank, and the inputs SHALL be first latched at the end of that scan.

Configuration
REQ-021 Macro SSD_BLINK_EN: when defined, REQ-017 and REQ-018 SHALL apply; when undefined, the blink counter and phase logic SHALL NOT be built, blink_mask and alert SHALL be ignored, and no digit SHALL ever be blanked by blinking.

Verification (REFRESH_DIV=8, DEAD_CYC=2, BLINK_DIV=64)
REQ-022 Hold rst high, then release; apply ssd={C,L,S,d} -> the first 32 cycles show AN sequence 0111,1011,1101,1110 (each preceded by 2 cycles of 1111) with seven_out=1111111 throughout; the next scan shows C, L, S, d.
REQ-023 ssd={0,1,2,3}, then change to {4,5,6,7} while idx=2 -> the current scan completes showing 0,1,2,3; the following scan shows 4,5,6,7.
REQ-024 ssd={O,P,E,n}, blink_mask=4'b1000, SSD_BLINK_EN defined -> digit 3 segments read 1111111 for 64 cycles and O for 64 cycles, alternating; digits 2-0 are steady.
REQ-025 alert=1, ssd={E,C,3,20} -> all four digits blank during phase 0 and show E,C,3,h during phase 1; with SSD_BLINK_EN undefined, the display is steady.
REQ-026 ssd codes 18, 19, 25 on digits 3-1 -> seven_out for digit 3 is 1111110, and for digits 2 and 1 is 1111111.
REQ-027 Assert rst at cnt=5, idx=1 -> AN=1111 and seven_out=1111111 in the same cycle; after release, idx restarts at 3.
